ccff_chain_loader: RTL and testbench
====================================

// Module: ccff_chain_loader
// PURPOSE
//  Serial configuration-chain programmer for IO grid tiles (e.g. the 8-subtile right IO column).
//  Accepts bitstream words over valid/ready and shifts them one bit per cycle into the tile's
//  ccff_head. Drives a shift enable for the prog_clk gate of the chain flops.
//  Signals completion after exactly CHAIN_LEN bits have been shifted.
// PARAMETERS
//  CHAIN_LEN  8   total configuration flops in the chain (>=1); bit counter is $clog2(CHAIN_LEN+1) wide
//  WORD_W     8   bitstream word width (>=1)
// PORTS
//  prog_clk       in   1       programming clock; all state on rising edge
//  pReset_n       in   1       asynchronous, active-low reset
//  start          in   1       1-cycle pulse; begins a load when idle
//  abort          in   1       synchronous abort; highest priority after reset
//  s_data         in   WORD_W  bitstream word; s_data[WORD_W-1] is shifted first
//  s_valid        in   1       word valid
//  s_ready        out  1       word accepted when s_valid&&s_ready
//  ccff_head      out  1       serial data into chain head
//  ccff_tail      in   1       serial data from chain tail (used only with readback)
//  ccff_shift_en  out  1       enables one prog_clk shift of the chain this cycle
//  busy           out  1       high in any state except IDLE
//  done           out  1       1-cycle pulse on successful completion
//  err            out  1       sticky until next start; readback mismatch
// BEHAVIOUR
//  Reset: FSM=IDLE; s_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, err=0; counters=0.
//  Reset assertion mid-load discards all progress. The chain contents are undefined and must be reloaded.
//  FSM states: IDLE, LOAD, SHIFT, VERIFY (readback build only), DONE.
//  IDLE: on start -> LOAD; clear bit_cnt and err.
//  LOAD: s_ready=1. On accept, latch s_data into shreg and set word_cnt=min(WORD_W, CHAIN_LEN-bit_cnt); -> SHIFT.
//  SHIFT: ccff_shift_en=1 and ccff_head=shreg[WORD_W-1] every cycle; shreg<<=1; bit_cnt++; word_cnt--.
//    When word_cnt hits 0: if bit_cnt==CHAIN_LEN -> VERIFY/DONE, otherwise -> LOAD.
//    A no-bubble path is not required: one LOAD cycle per word is acceptable.
//  Partial last word: only the first (CHAIN_LEN mod WORD_W) MSBs are shifted; the remaining LSBs are dropped.
//  First bit shifted ends at the tail (subtile 7); the last bit shifted sits at the head (subtile 0).
//  ccff_shift_en is high for exactly CHAIN_LEN cycles per load (2*CHAIN_LEN with readback).
//  DONE: done=1 for one cycle -> IDLE.
//  start while busy: ignored.
//  abort (any state): -> IDLE next cycle; shift_en=0; done is not pulsed; err unchanged.
//  abort has priority over a simultaneous start or s_valid.
//  s_valid with s_ready=0: word is not consumed and must be held by the source.
// CONFIGURATION
//  CCFF_READBACK_EN defined:
//    - A CRC-16-CCITT (0x1021, init 0xFFFF) is computed over every bit driven on ccff_head during SHIFT.
//    - VERIFY recirculates the chain for CHAIN_LEN cycles: ccff_head=ccff_tail, shift_en=1.
//      This leaves the contents intact; a second CRC is computed over ccff_tail.
//    - On exit from VERIFY, a CRC mismatch sets err=1 and still passes through DONE (done pulses).
//  CCFF_READBACK_EN undefined: no VERIFY state and no CRC logic. ccff_tail is ignored; err is tied to 0.
// STRUCTURE
//  Package ccff_loader_pkg: state enum, CRC16_POLY, CRC16_INIT constants.
//  Sub-module ccff_crc16_serial: 1-bit/cycle CRC with clr/en/din ports, instantiated twice under the macro.
//  Bench chain model: CHAIN_LEN-deep shift register clocked when ccff_shift_en=1.
// TESTING
//  1. CHAIN_LEN=8, WORD_W=8, start, word 8'hA5 -> 8 shift cycles with head sequence 1,0,1,0,0,1,0,1;
//     done pulses once; model reads tail->head = A5 bits.
//  2. CHAIN_LEN=12, WORD_W=8, words 8'hFF, 8'h3C -> 12 shift cycles, 4 low bits of 3C dropped,
//     s_ready high exactly 2 cycles, done once.
//  3. s_valid deasserted for 5 cycles between words -> s_ready stays high and shift_en stays low
//     through the gap; the final chain contents are unchanged versus the no-gap run.
//  4. abort after 3 shift cycles -> busy=0 next cycle, no done, shift_en low.
//     A subsequent start reloads correctly.
//  5. start pulsed while busy, and pReset_n asserted mid-SHIFT -> start ignored.
//     After reset, all outputs are 0 and FSM=IDLE.
//  6. Readback on: faithful model -> 16 shift cycles, err=0. Model with a stuck-at-0 flop at
//     position 3 -> err=1, done still pulses.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// rtl/ccff_loader_pkg.sv - shared state encoding and CRC constants for the chain loader
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_VERIFY,
    ST_DONE
  } ccff_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage

// File: rtl/ccff_crc16_serial.sv
// rtl/ccff_crc16_serial.sv - bit-serial CRC-16-CCITT, one input bit per enabled cycle
module ccff_crc16_serial (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc,
  output logic [15:0] crc_nxt
);
  import ccff_loader_pkg::*;

  logic feedback;

  assign feedback = crc[15] ^ din;
  assign crc_nxt  = {crc[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC16_INIT;
    end else if (clr) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc_nxt;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serial configuration-chain programmer; CCFF_READBACK_EN adds CRC readback verify
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import ccff_loader_pkg::*;

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WC_W  = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WC_W-1:0]  WORD_FULL = WC_W'(WORD_W);

  ccff_state_e       state, state_nxt;
  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bits_left;
  logic [WC_W-1:0]   word_cnt;
  logic [WC_W-1:0]   word_len;
  logic              word_last;
  logic              chain_last;

  // A short final word only shifts the bits the chain still needs.
  assign bits_left  = CNT_W'(CHAIN_LEN) - bit_cnt;
  assign word_len   = (32'(bits_left) >= 32'(WORD_W)) ? WORD_FULL : WC_W'(bits_left);
  assign word_last  = (word_cnt == WC_W'(1));
  assign chain_last = (bit_cnt == LAST_BIT);

`ifdef CCFF_READBACK_EN
  logic        err_q;
  logic        verify_last;
  logic [15:0] crc_head;
  logic [15:0] crc_tail_nxt;
  logic [15:0] unused_head_nxt;
  logic [15:0] unused_tail_crc;

  // VERIFY counts bit_cnt back down from CHAIN_LEN.
  assign verify_last = (bit_cnt == CNT_W'(1));

  ccff_crc16_serial u_crc_head (
    .clk     (prog_clk),
    .rst_n   (pReset_n),
    .clr     ((state == ST_IDLE) && start && !abort),
    .en      ((state == ST_SHIFT) && !abort),
    .din     (ccff_head),
    .crc     (crc_head),
    .crc_nxt (unused_head_nxt)
  );

  ccff_crc16_serial u_crc_tail (
    .clk     (prog_clk),
    .rst_n   (pReset_n),
    .clr     ((state == ST_IDLE) && start && !abort),
    .en      ((state == ST_VERIFY) && !abort),
    .din     (ccff_tail),
    .crc     (unused_tail_crc),
    .crc_nxt (crc_tail_nxt)
  );

  assign err = err_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD:  if (s_valid) state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (word_last) begin
`ifdef CCFF_READBACK_EN
          state_nxt = chain_last ? ST_VERIFY : ST_LOAD;
`else
          state_nxt = chain_last ? ST_DONE : ST_LOAD;
`endif
        end
      end
`ifdef CCFF_READBACK_EN
      ST_VERIFY: if (verify_last) state_nxt = ST_DONE;
`endif
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  always_comb begin
    ccff_head = 1'b0;
    if (state == ST_SHIFT) ccff_head = shreg[WORD_W-1];
`ifdef CCFF_READBACK_EN
    else if (state == ST_VERIFY) ccff_head = ccff_tail;
`endif
  end

  assign s_ready       = (state == ST_LOAD) && !abort;
  assign ccff_shift_en = ((state == ST_SHIFT) || (state == ST_VERIFY)) && !abort;
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE) && !abort;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
`ifdef CCFF_READBACK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (!abort) begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              bit_cnt <= '0;
`ifdef CCFF_READBACK_EN
              err_q   <= 1'b0;
`endif
            end
          end
          ST_LOAD: begin
            if (s_valid) begin
              shreg    <= s_data;
              word_cnt <= word_len;
            end
          end
          ST_SHIFT: begin
            shreg    <= shreg << 1;
            bit_cnt  <= bit_cnt + CNT_W'(1);
            word_cnt <= word_cnt - WC_W'(1);
          end
`ifdef CCFF_READBACK_EN
          ST_VERIFY: begin
            bit_cnt <= bit_cnt - CNT_W'(1);
            if (verify_last) err_q <= (crc_head != crc_tail_nxt);
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - self-checking bench for ccff_chain_loader (8- and 12-flop chains); honours CCFF_READBACK_EN
module tb_ccff_chain_loader;
  import ccff_loader_pkg::*;

`ifdef CCFF_READBACK_EN
  localparam int RB = 2;
`else
  localparam int RB = 1;
`endif

  logic       prog_clk;
  logic       pReset_n;
  logic       abort;
  logic       s_valid;
  logic [7:0] s_data;
  logic [1:0] start, s_ready, head, tail, shift_en, busy, done, err;

  logic [7:0]  chain0 = '0;
  logic [11:0] chain1 = '0;
  logic [7:0]  nxt0;
  logic        stuck;
  logic        mon_clr;

  int          n_cmp, n_bad;
  int          shift_cnt[2];
  int          ready_cnt[2];
  int          done_cnt[2];
  logic [31:0] head_rec[2];
  logic        err_at_done[2];
  logic [7:0]  wv[4];

  ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) u_dut0 (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start[0]), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready[0]), .ccff_head(head[0]),
    .ccff_tail(tail[0]), .ccff_shift_en(shift_en[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) u_dut1 (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start[1]), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready[1]), .ccff_head(head[1]),
    .ccff_tail(tail[1]), .ccff_shift_en(shift_en[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  initial begin
    prog_clk = 1'b0;
    forever #5 prog_clk = ~prog_clk;
  end

  // Physical chain models: position 0 is the head, the top index is the tail.
  assign nxt0 = {chain0[6:0], head[0]} & (stuck ? 8'hF7 : 8'hFF);
  assign tail = {chain1[11], chain0[7]};

  always @(posedge prog_clk) begin
    if (shift_en[0]) chain0 <= nxt0;
    if (shift_en[1]) chain1 <= {chain1[10:0], head[1]};
  end

  always @(posedge prog_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mon_clr) begin
        shift_cnt[i]   <= 0;
        ready_cnt[i]   <= 0;
        done_cnt[i]    <= 0;
        head_rec[i]    <= '0;
        err_at_done[i] <= 1'b0;
      end else if (pReset_n) begin
        if (shift_en[i]) begin
          if (shift_cnt[i] < 32) head_rec[i][shift_cnt[i]] <= head[i];
          shift_cnt[i] <= shift_cnt[i] + 1;
        end
        if (s_ready[i]) ready_cnt[i] <= ready_cnt[i] + 1;
        if (done[i]) begin
          done_cnt[i]    <= done_cnt[i] + 1;
          err_at_done[i] <= err[i];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge prog_clk);
    mon_clr = 1'b0;
  endtask

  task automatic wait_ready(input int sel);
    int t;
    t = 0;
    while (!s_ready[sel] && t < 100) begin
      @(negedge prog_clk);
      t++;
    end
    chk("s_ready_wait", 32'(s_ready[sel]), 32'd1);
  endtask

  task automatic do_load(input int sel, input int nw, input int gap, input bit extra_start);
    int t;
    clear_mon();
    start[sel] = 1'b1;
    @(negedge prog_clk);
    start[sel] = 1'b0;
    for (int k = 0; k < nw; k++) begin
      if (k > 0 && gap > 0) begin
        wait_ready(sel);
        for (int g = 0; g < gap; g++) begin
          chk("gap_s_ready", 32'(s_ready[sel]), 32'd1);
          chk("gap_shift_en", 32'(shift_en[sel]), 32'd0);
          @(negedge prog_clk);
        end
      end
      s_data  = wv[k];
      s_valid = 1'b1;
      wait_ready(sel);
      @(negedge prog_clk);
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      if (extra_start && k == 0) begin
        start[sel] = 1'b1;
        @(negedge prog_clk);
        start[sel] = 1'b0;
        chk("busy_after_restart", 32'(busy[sel]), 32'd1);
      end
    end
    t = 0;
    while (done_cnt[sel] == 0 && t < 300) begin
      @(negedge prog_clk);
      t++;
    end
    repeat (4) @(negedge prog_clk);
  endtask

  // Reference: bits leave MSB-first from each word, truncated to the chain length;
  // the first bit shifted finishes at the tail.
  task automatic check_load(input int sel, input bit exp_err);
    int L;
    logic [15:0] exp_c, obs_c, exp_h, obs_h;
    logic b;
    L = (sel == 1) ? 12 : 8;
    exp_c = '0; exp_h = '0; obs_h = '0;
    for (int k = 0; k < L; k++) begin
      b = wv[k / 8][7 - (k % 8)];
      exp_c[L - 1 - k] = b;
      exp_h[k]         = b;
      obs_h[k]         = head_rec[sel][k];
    end
    obs_c = (sel == 1) ? {4'b0, chain1} : {8'b0, chain0};
    chk("shift_cycles", 32'(shift_cnt[sel]), 32'(L * RB));
    chk("done_pulses", 32'(done_cnt[sel]), 32'd1);
    chk("head_sequence", 32'(obs_h), 32'(exp_h));
    if (!exp_err) chk("chain_contents", 32'(obs_c), 32'(exp_c));
    chk("err_at_done", 32'(err_at_done[sel]), 32'(exp_err));
    chk("busy_after_done", 32'(busy[sel]), 32'd0);
  endtask

  task automatic rand_words();
    for (int i = 0; i < 4; i++) wv[i] = 8'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    n_cmp = 0; n_bad = 0;
    pReset_n = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    start = '0; stuck = 1'b0; mon_clr = 1'b0;
    repeat (3) @(negedge prog_clk);
    chk("reset_outputs", 32'({s_ready, head, shift_en, busy, done, err}), 32'd0);
    pReset_n = 1'b1;
    @(negedge prog_clk);

    // Single full word into the 8-flop chain.
    wv[0] = 8'hA5;
    do_load(0, 1, 0, 0);
    check_load(0, 1'b0);
    chk("a5_head_bits", 32'(head_rec[0][7:0]), 32'h0000_00A5 ^ 32'h0000_0000 ? 32'({<<{8'hA5}}) : 32'd0);
    chk("a5_chain", 32'(chain0), 32'h0000_00A5);

    // Partial last word into the 12-flop chain.
    wv[0] = 8'hFF; wv[1] = 8'h3C;
    do_load(1, 2, 0, 0);
    check_load(1, 1'b0);
    chk("ff3c_ready_cycles", 32'(ready_cnt[1]), 32'd2);
    chk("ff3c_chain", 32'(chain1), 32'h0000_0FF3);

    // Randomized loads with random inter-word gaps.
    for (int r = 0; r < 6; r++) begin
      rand_words();
      do_load(r % 2, (r % 2 == 1) ? 2 : 1, int'($urandom_range(0, 3)), 0);
      check_load(r % 2, 1'b0);
    end

    // Stalled source between words must not disturb the result.
    wv[0] = 8'hFF; wv[1] = 8'h3C;
    do_load(1, 2, 5, 0);
    check_load(1, 1'b0);
    chk("gap_chain", 32'(chain1), 32'h0000_0FF3);

    // Abort after three shifts, then a clean reload.
    rand_words();
    clear_mon();
    start[1] = 1'b1;
    @(negedge prog_clk);
    start[1] = 1'b0;
    s_data = wv[0]; s_valid = 1'b1;
    wait_ready(1);
    @(negedge prog_clk);
    s_valid = 1'b0;
    t = 0;
    while (shift_cnt[1] < 3 && t < 50) begin
      @(negedge prog_clk);
      t++;
    end
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy[1]), 32'd0);
    chk("abort_shift_en", 32'(shift_en[1]), 32'd0);
    chk("abort_shift_count", 32'(shift_cnt[1]), 32'd3);
    repeat (5) @(negedge prog_clk);
    chk("abort_no_done", 32'(done_cnt[1]), 32'd0);
    rand_words();
    do_load(1, 2, 0, 0);
    check_load(1, 1'b0);

    // Start pulsed while busy is ignored.
    rand_words();
    do_load(1, 2, 0, 1);
    check_load(1, 1'b0);

    // Reset in the middle of a shift.
    rand_words();
    clear_mon();
    start[1] = 1'b1;
    @(negedge prog_clk);
    start[1] = 1'b0;
    s_data = wv[0]; s_valid = 1'b1;
    wait_ready(1);
    @(negedge prog_clk);
    s_valid = 1'b0;
    repeat (2) @(negedge prog_clk);
    chk("pre_reset_shift_en", 32'(shift_en[1]), 32'd1);
    pReset_n = 1'b0;
    #1;
    chk("mid_reset_outputs", 32'({s_ready, head, shift_en, busy, done, err}), 32'd0);
    chk("mid_reset_state", 32'(u_dut1.state), 32'(ST_IDLE));
    @(negedge prog_clk);
    pReset_n = 1'b1;
    @(negedge prog_clk);
    rand_words();
    do_load(0, 1, 0, 0);
    check_load(0, 1'b0);

`ifdef CCFF_READBACK_EN
    // Readback with a faithful chain, then with flop 3 stuck at zero.
    rand_words();
    do_load(0, 1, 0, 0);
    check_load(0, 1'b0);
    stuck = 1'b1;
    wv[0] = 8'hFF;
    do_load(0, 1, 0, 0);
    check_load(0, 1'b1);
    chk("stuck_err_sticky", 32'(err[0]), 32'd1);
    stuck = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
